// File: rtl/add_pkg.sv
// Shared constants and the operation encoding for the pipelined adder/subtractor.
package add_pkg;

   localparam int unsigned DEF_WIDTH  = 32;
   localparam int unsigned DEF_STAGES = 4;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple slice: sum, carry-out and signed overflow of its MSB.
module add_chunk #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_c,
   output logic [W-1:0] o_sum_c,
   output logic         o_cout_c,
   output logic         o_ovf_c
);

   logic [W:0] w_full;

   assign w_full   = {1'b0, i_a} + {1'b0, i_b} + (W+1)'(i_c);
   assign o_sum_c  = w_full[W-1:0];
   assign o_cout_c = w_full[W];
   // Overflow only matters on the top slice; lower slices leave it unused.
   assign o_ovf_c  = (i_a[W-1] == i_b[W-1]) && (w_full[W-1] != i_a[W-1]);

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-wide slice per stage with operand skew
// and result de-skew registers, all stages sharing one advance enable.
module pipe_add_sub
   import add_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int unsigned CHUNK = WIDTH / STAGES;

   logic             w_adv;
   op_e              w_op;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign w_adv     = out_ready || !out_valid;
   assign in_ready  = w_adv;
   assign w_op      = sub ? OP_SUB : OP_ADD;
   assign w_b_eff   = (w_op == OP_SUB) ? ~b : b;
   assign w_cin_eff = (w_op == OP_SUB) ? ~c_in : c_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int unsigned DONE = k * CHUNK;
      localparam int unsigned PEND = WIDTH - DONE;

      logic [PEND-1:0]       w_a;
      logic [PEND-1:0]       w_b;
      logic                  w_cy;
      logic                  w_vld;
      logic [CHUNK-1:0]      w_s;
      logic                  w_co;
      logic                  w_ov;
      logic [DONE+CHUNK-1:0] w_lo;

      logic                  r_vld;
      logic                  r_cy;
      logic [DONE+CHUNK-1:0] r_lo;

      if (k == 0) begin : g_first
         assign w_a   = a;
         assign w_b   = w_b_eff;
         assign w_cy  = w_cin_eff;
         assign w_vld = in_valid;
         assign w_lo  = w_s;
      end else begin : g_next
         assign w_a   = g_stg[k-1].g_mid.r_a;
         assign w_b   = g_stg[k-1].g_mid.r_b;
         assign w_cy  = g_stg[k-1].r_cy;
         assign w_vld = g_stg[k-1].r_vld;
         assign w_lo  = {w_s, g_stg[k-1].r_lo};
      end

      add_chunk #(.W(CHUNK)) u_chunk (
         .i_a      (w_a[CHUNK-1:0]),
         .i_b      (w_b[CHUNK-1:0]),
         .i_c      (w_cy),
         .o_sum_c  (w_s),
         .o_cout_c (w_co),
         .o_ovf_c  (w_ov)
      );

      if (k < STAGES - 1) begin : g_mid
         logic [PEND-CHUNK-1:0] r_a;
         logic [PEND-CHUNK-1:0] r_b;
         logic                  w_unused_ov;

         assign w_unused_ov = w_ov;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= 1'b0;
            end else if (w_adv) begin
               r_vld <= w_vld;
            end
         end

         // Datapath: upper operand chunks ride along, finished low chunks accumulate.
         always_ff @(posedge clk) begin
            if (w_adv) begin
               r_cy <= w_co;
               r_lo <= w_lo;
               r_a  <= w_a[PEND-1:CHUNK];
               r_b  <= w_b[PEND-1:CHUNK];
            end
         end
      end else begin : g_last
         logic r_ov;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= 1'b0;
               r_cy  <= 1'b0;
               r_lo  <= '0;
               r_ov  <= 1'b0;
            end else if (w_adv) begin
               r_vld <= w_vld;
               r_cy  <= w_co;
               r_lo  <= w_lo;
               r_ov  <= w_ov;
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].r_vld;
   assign sum       = g_stg[STAGES-1].r_lo;
   assign c_out     = g_stg[STAGES-1].r_cy;
   assign ovf       = g_stg[STAGES-1].g_last.r_ov;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed and streamed checks of pipe_add_sub in 8/2, 8/1 and 32/4 configurations.
module tb_pipe_add_sub;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // shared 8-bit stimulus for the 2-stage and 1-stage instances
   logic       v8, c8, s8, ordy8;
   logic [7:0] a8, b8;
   logic       rdy8, vld8, co8, ovf8;
   logic [7:0] sum8;
   logic       rdy1, vld1, co1, ovf1;
   logic [7:0] sum1;

   logic        v32, c32, s32, ordy32;
   logic [31:0] a32, b32;
   logic        rdy32, vld32, co32, ovf32;
   logic [31:0] sum32;

   pipe_add_sub #(.WIDTH(8), .STAGES(2)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
      .c_in(c8), .sub(s8), .out_valid(vld8), .out_ready(ordy8), .sum(sum8),
      .c_out(co8), .ovf(ovf8));

   pipe_add_sub #(.WIDTH(8), .STAGES(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy1), .a(a8), .b(b8),
      .c_in(c8), .sub(s8), .out_valid(vld1), .out_ready(ordy8), .sum(sum1),
      .c_out(co1), .ovf(ovf1));

   pipe_add_sub #(.WIDTH(32), .STAGES(4)) u_d32 (
      .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .a(a32), .b(b32),
      .c_in(c32), .sub(s32), .out_valid(vld32), .out_ready(ordy32), .sum(sum32),
      .c_out(co32), .ovf(ovf32));

   typedef struct {
      logic [7:0] a, b;
      logic       ci, sb;
      logic [7:0] s;
      logic       co, ov;
   } v8_t;

   typedef struct {
      logic [31:0] a, b;
      logic        ci, sb;
      logic [31:0] s;
      logic        co, ov;
   } v32_t;

   typedef struct {
      logic [31:0] s;
      logic        co, ov;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   n_run  = 0;
   int   n_fail = 0;
   int   n_pop  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Integer reference: true unsigned carry/borrow and true signed range overflow.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic sb);
      longint m, half, ux, uy, sx, sy, c, u, ex;
      logic   co, ov;
      m    = (longint'(1) << 32) - 1;
      half = longint'(1) << 31;
      ux   = longint'(x);
      uy   = longint'(y);
      c    = longint'(ci);
      sx   = (ux >= half) ? ux - 2 * half : ux;
      sy   = (uy >= half) ? uy - 2 * half : uy;
      if (!sb) begin
         u  = ux + uy + c;
         co = (u > m);
         ex = sx + sy + c;
      end else begin
         u  = ux - uy - c;
         co = (u >= 0);
         ex = sx - sy - c;
      end
      ov = (ex >= half) || (ex < -half);
      return {ov, co, 32'(u & m)};
   endfunction

   // One cycle on the 32-bit instance: drive, score the presented output, log acceptance.
   task automatic step32(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input logic sb, input logic [33:0] e,
                         input logic ordy, input bit lat, output bit acc);
      exp_t ent;
      @(negedge clk);
      v32 = v; a32 = x; b32 = y; c32 = ci; s32 = sb; ordy32 = ordy;
      #1;
      acc = 1'b0;
      if (vld32) begin
         if (q.size() == 0) begin
            chk("spurious_out", 32'(vld32), 32'd0);
         end else begin
            chk("sum32", sum32, q[0].s);
            chk("cout32", 32'(co32), 32'(q[0].co));
            chk("ovf32", 32'(ovf32), 32'(q[0].ov));
            if (lat) chk("latency32", cyc - q[0].acc, 32'd4);
            if (ordy) begin
               void'(q.pop_front());
               n_pop++;
            end
         end
      end
      if (!ordy && vld32) chk("stall_in_ready", 32'(rdy32), 32'd0);
      if (v && rdy32 && rst_n) begin
         ent.s = e[31:0]; ent.co = e[32]; ent.ov = e[33]; ent.acc = cyc;
         q.push_back(ent);
         acc = 1'b1;
      end
   endtask

   task automatic drain(input bit lat);
      bit acc;
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         step32(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, lat, acc);
         n++;
      end
      chk("drain_empty", q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   v8_t         tab8[11];
   v32_t        tab32[4];
   bit          acc;
   int          base, idx;
   logic [31:0] rx[6], ry[6];
   logic        rc[6], rs[6];

   initial begin
      tab8[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tab8[1]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      tab8[2]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      tab8[3]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tab8[4]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
      tab8[5]  = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};
      tab8[6]  = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
      tab8[7]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      tab8[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      tab8[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
      tab8[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

      tab32[0] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h7FFFFFFE, 1'b1, 1'b0};
      tab32[1] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0};
      tab32[2] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0};
      tab32[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};

      rst_n = 1'b0;
      v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; s8 = 1'b0; ordy8 = 1'b1;
      v32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0; s32 = 1'b0; ordy32 = 1'b1;

      #12;
      chk("rst_vld8", 32'(vld8), 32'd0);
      chk("rst_sum8", 32'(sum8), 32'd0);
      chk("rst_co8", 32'(co8), 32'd0);
      chk("rst_ovf8", 32'(ovf8), 32'd0);
      chk("rst_rdy8", 32'(rdy8), 32'd1);
      chk("rst_vld1", 32'(vld1), 32'd0);
      chk("rst_vld32", 32'(vld32), 32'd0);
      chk("rst_sum32", sum32, 32'd0);
      chk("rst_rdy32", 32'(rdy32), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // single beats: 1-stage result after one edge, 2-stage after two
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         v8 = 1'b1; a8 = tab8[i].a; b8 = tab8[i].b; c8 = tab8[i].ci; s8 = tab8[i].sb;
         @(negedge clk);
         v8 = 1'b0;
         #1;
         chk($sformatf("v%0d_vld1", i), 32'(vld1), 32'd1);
         chk($sformatf("v%0d_sum1", i), 32'(sum1), 32'(tab8[i].s));
         chk($sformatf("v%0d_co1", i), 32'(co1), 32'(tab8[i].co));
         chk($sformatf("v%0d_ovf1", i), 32'(ovf1), 32'(tab8[i].ov));
         chk($sformatf("v%0d_early8", i), 32'(vld8), 32'd0);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_vld8", i), 32'(vld8), 32'd1);
         chk($sformatf("v%0d_sum8", i), 32'(sum8), 32'(tab8[i].s));
         chk($sformatf("v%0d_co8", i), 32'(co8), 32'(tab8[i].co));
         chk($sformatf("v%0d_ovf8", i), 32'(ovf8), 32'(tab8[i].ov));
         chk($sformatf("v%0d_bubble1", i), 32'(vld1), 32'd0);
      end

      // alternating mode and carry-in, back to back
      for (int i = 0; i < 4; i++) begin
         step32(1'b1, tab32[i].a, tab32[i].b, tab32[i].ci, tab32[i].sb,
                {tab32[i].ov, tab32[i].co, tab32[i].s}, 1'b1, 1'b1, acc);
         chk("alt_accept", 32'(acc), 32'd1);
      end
      drain(1'b1);

      // 100 random beats back to back
      base = n_pop;
      for (int i = 0; i < 100; i++) begin
         logic [31:0] x, y;
         logic        ci, sb;
         x = $urandom; y = $urandom; ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
         step32(1'b1, x, y, ci, sb, model(x, y, ci, sb), 1'b1, 1'b1, acc);
         chk("rand_accept", 32'(acc), 32'd1);
      end
      drain(1'b1);
      chk("rand_count", n_pop - base, 32'd100);

      // output stalled for 3 cycles while results are pending
      for (int i = 0; i < 6; i++) begin
         rx[i] = $urandom; ry[i] = $urandom;
         rc[i] = 1'(i & 1); rs[i] = 1'((i >> 1) & 1);
      end
      base = n_pop;
      idx  = 0;
      for (int k = 0; k < 30 && idx < 6; k++) begin
         step32(1'b1, rx[idx], ry[idx], rc[idx], rs[idx],
                model(rx[idx], ry[idx], rc[idx], rs[idx]),
                (k >= 5 && k < 8) ? 1'b0 : 1'b1, 1'b0, acc);
         if (acc) idx++;
      end
      drain(1'b0);
      chk("stall_count", n_pop - base, 32'd6);

      // reset with beats in flight
      for (int i = 0; i < 4; i++) begin
         step32(1'b1, 32'h1000 + 32'(i), 32'h1, 1'b0, 1'b0,
                model(32'h1000 + 32'(i), 32'h1, 1'b0, 1'b0), 1'b1, 1'b1, acc);
      end
      @(negedge clk);
      v32 = 1'b0;
      #1;
      chk("pre_rst_vld", 32'(vld32), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", 32'(vld32), 32'd0);
      chk("mid_rst_sum", sum32, 32'd0);
      chk("mid_rst_co", 32'(co32), 32'd0);
      chk("mid_rst_ovf", 32'(ovf32), 32'd0);
      chk("mid_rst_rdy", 32'(rdy32), 32'd1);
      q.delete();
      step32(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
      step32(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
      @(negedge clk);
      rst_n = 1'b1;
      v32 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step32(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
         chk("post_rst_idle", 32'(vld32), 32'd0);
      end
      step32(1'b1, 32'h00000005, 32'h00000007, 1'b0, 1'b1,
             model(32'h00000005, 32'h00000007, 1'b0, 1'b1), 1'b1, 1'b1, acc);
      chk("post_rst_accept", 32'(acc), 32'd1);
      drain(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
